// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative 32x32 radix-2 shift-add multiplier, 64-bit product.
//
// One multiply in flight. A start seen in IDLE or DONE captures the operands;
// 32 RUN cycles later the product lands on hi/lo with a one-cycle done pulse.
// A start during the done cycle is accepted, so back-to-back multiplies
// issue with no idle cycle.
//
// Build option: define SEQ_MULT_SIGNED_EN to compile in two's-complement
// support (magnitude at capture, negate at completion, chosen by is_signed).
// Without it is_signed is ignored and every multiply is unsigned.
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   asynchronous, active-low
//   start      in   multiply request, sampled when not busy
//   a, b       in   32-bit multiplicand / multiplier
//   is_signed  in   operands are two's complement (option only)
//   busy       out  multiply in progress
//   done       out  one-cycle pulse, hi/lo newly updated
//   hi, lo     out  product [63:32] / [31:0], held until next completion
//
// state | meaning
// IDLE  | waiting for start (reset state)
// RUN   | 32 shift-add iterations
// DONE  | product valid, one cycle; start here chains the next multiply
module seq_multiplier (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        last_iter;
  logic [31:0] mcand_in, mplier_in;
  logic [32:0] sum;
  logic [63:0] prod_raw, prod_final;

  assign accept    = (state_q != S_RUN) && start;
  assign last_iter = (state_q == S_RUN) && (cnt_q == 5'd31);

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q, sign_d;

  assign mcand_in   = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign mplier_in  = (is_signed && b[31]) ? (~b + 32'd1) : b;
  assign sign_d     = accept ? (is_signed & (a[31] ^ b[31])) : sign_q;
  assign prod_final = sign_q ? (~prod_raw + 64'd1) : prod_raw;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sign_q <= 1'b0;
    else        sign_q <= sign_d;
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign mcand_in   = a;
  assign mplier_in  = b;
  assign prod_final = prod_raw;
`endif

  // The 33-bit accumulator is the sum itself; its shifted-down upper 32 bits
  // are all that needs to be held between iterations.
  assign sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign prod_raw = {sum, mplier_q[31:1]};

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_iter ? S_DONE : S_RUN;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so both are glitch-free
  // and mutually exclusive.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Datapath next-state
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept) begin
      mcand_d  = mcand_in;
      mplier_d = mplier_in;
      acc_d    = 32'd0;
      cnt_d    = 5'd0;
    end else if (state_q == S_RUN) begin
      acc_d    = sum[32:1];
      mplier_d = {sum[0], mplier_q[31:1]};
      cnt_d    = cnt_q + 5'd1;
      if (last_iter) begin
        hi_d = prod_final[63:32];
        lo_d = prod_final[31:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] last_prod = '0;

  seq_multiplier dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .is_signed(is_signed), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Reference: plain arithmetic product, signed only when the option is built.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic s_eff;
    logic [63:0] ux, uy;
    logic signed [63:0] sx, sy;
    s_eff = s;
`ifndef SEQ_MULT_SIGNED_EN
    s_eff = 1'b0;
`endif
    ux = {32'b0, x};
    uy = {32'b0, y};
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (s_eff) return sx * sy;
    return ux * uy;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one multiply from IDLE/DONE and observe it; operands are scrambled
  // right after the accepting edge.
  task automatic do_mult(input logic [31:0] ai, input logic [31:0] bi, input logic si,
                         output logic [63:0] got, output int lat,
                         output logic busy0, output logic overlap);
    a = ai; b = bi; is_signed = si; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom);
    busy0 = busy;
    overlap = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (busy && done) overlap = 1'b1;
      if (done) begin lat = k; break; end
    end
    got = {hi, lo};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (hi !== 32'd0)   begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0)   begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vs [4];
    logic [63:0] ve [4];
    logic [63:0] got;
    int lat;
    logic busy0, overlap;
    va[0] = 32'd3;        vb[0] = 32'd5;        vs[0] = 1'b0; ve[0] = 64'h00000000_0000000F;
    va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vs[1] = 1'b0; ve[1] = 64'hFFFFFFFE_00000001;
    va[2] = 32'hFFFFFFFD; vb[2] = 32'd5;        vs[2] = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
    ve[2] = 64'hFFFFFFFF_FFFFFFF1;
`else
    ve[2] = 64'h00000004_FFFFFFF1;
`endif
    va[3] = 32'h80000000; vb[3] = 32'h80000000; vs[3] = 1'b1; ve[3] = 64'h40000000_00000000;
    for (int i = 0; i < 4; i++) begin
      do_mult(va[i], vb[i], vs[i], got, lat, busy0, overlap);
      last_prod = ve[i];
      n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL dir%0d_busy_after_start got %b want 1", i, busy0); end
      n_cmp++; if (lat != 32)      begin n_bad++; $display("FAIL dir%0d_latency got %0d want 32", i, lat); end
      n_cmp++; if (overlap !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_done_overlap got 1 want 0", i); end
      n_cmp++; if (got !== ve[i])  begin n_bad++; $display("FAIL dir%0d_product got %h want %h", i, got, ve[i]); end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse got done=%b busy=%b want 0 0", i, done, busy); end
      n_cmp++; if ({hi, lo} !== ve[i]) begin n_bad++; $display("FAIL dir%0d_hold got %h want %h", i, {hi, lo}, ve[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic rs;
    logic [63:0] got, exp;
    int lat;
    logic busy0, overlap;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i == 0) ra = 32'd0;
      if (i == 1) rb = 32'h80000000;
      exp = model(ra, rb, rs);
      do_mult(ra, rb, rs, got, lat, busy0, overlap);
      last_prod = exp;
      n_cmp++; if (got !== exp || lat != 32 || overlap !== 1'b0)
        begin n_bad++; $display("FAIL rand%0d a=%h b=%h s=%b got %h lat %0d want %h lat 32", i, ra, rb, rs, got, lat, exp); end
      if (i % 3 == 0) tick();
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [63:0] prev;
    prev = last_prod;
    a = 32'd7; b = 32'd9; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 5) begin a = 32'd2; b = 32'd2; start = 1'b1; end
      tick();
      if (k == 5) begin
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy got %b want 1", busy); end
        n_cmp++; if ({hi, lo} !== prev) begin n_bad++; $display("FAIL ign_hold_midrun got %h want %h", {hi, lo}, prev); end
      end
      if (done) begin lat = k; break; end
    end
    n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL ign_latency got %0d want 32", lat); end
    n_cmp++; if ({hi, lo} !== 64'd63) begin n_bad++; $display("FAIL ign_product got %h want 63", {hi, lo}); end
    // restart in the done cycle
    a = 32'd2; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL restart_in_done got busy=%b done=%b want 1 0", busy, done); end
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL restart_latency got %0d want 32", lat); end
    n_cmp++; if ({hi, lo} !== 64'd4) begin n_bad++; $display("FAIL restart_product got %h want 4", {hi, lo}); end
    last_prod = 64'd4;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa [6];
    logic [31:0] qb [6];
    logic        qs [6];
    int lat;
    logic [63:0] exp;
    for (int i = 0; i < 6; i++) begin qa[i] = $urandom; qb[i] = $urandom; qs[i] = 1'($urandom); end
    a = qa[0]; b = qb[0]; is_signed = qs[0]; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
        tick();
        if (done) begin lat = k; break; end
      end
      exp = model(qa[i], qb[i], qs[i]);
      last_prod = exp;
      n_cmp++; if (lat != 32 || {hi, lo} !== exp)
        begin n_bad++; $display("FAIL b2b%0d got %h lat %0d want %h lat 32", i, {hi, lo}, lat, exp); end
      if (i < 5) begin
        a = qa[i+1]; b = qb[i+1]; is_signed = qs[i+1]; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom;
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0)
          begin n_bad++; $display("FAIL b2b%0d_restart got busy=%b done=%b want 1 0", i, busy, done); end
      end
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    logic seen_done;
    logic [63:0] got;
    int lat;
    logic busy0, overlap;
    a = 32'd7; b = 32'd9; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0)
      begin n_bad++; $display("FAIL midrst_ctrl got busy=%b done=%b want 0 0", busy, done); end
    n_cmp++; if ({hi, lo} !== 64'd0)
      begin n_bad++; $display("FAIL midrst_product got %h want 0 (was %h)", {hi, lo}, last_prod); end
    tick(); tick();
    reset = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done got activity want none"); end
    do_mult(32'd6, 32'd7, 1'b0, got, lat, busy0, overlap);
    n_cmp++; if (got !== 64'd42 || lat != 32)
      begin n_bad++; $display("FAIL midrst_after got %h lat %0d want 42 lat 32", got, lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative 32x32 radix-2 shift-add multiplier producing a 64-bit product over 32 cycles. It sits directly upstream of the HI/LO 32-bit load-enable registers. `hi` and `lo` drive the registers' data inputs, and the one-cycle `done` pulse drives their load selects, so each register captures the product on the edge after completion. Start/busy/done handshake; one multiply in flight at a time.

## Interface
Parameters:
- none; width fixed at 32-bit operands, 64-bit product.

Ports:
- `clock` — input, 1 — sole clock; all state updates on the rising edge.
- `reset` — input, 1 — asynchronous, active-low; forces all state and outputs to reset values.
- `start` — input, 1 — request a multiply; sampled on the rising edge of `clock` when not busy.
- `a` — input, 32 — multiplicand; captured on the accepting edge.
- `b` — input, 32 — multiplier; captured on the accepting edge.
- `is_signed` — input, 1 — operands are two's complement; captured with `a`/`b`. Ignored unless SEQ_MULT_SIGNED_EN is defined.
- `busy` — output, 1 — a multiply is in progress.
- `done` — output, 1 — one-cycle pulse; `hi`/`lo` are valid and newly updated.
- `hi` — output, 32 — product bits [63:32]; holds its value until the next completion.
- `lo` — output, 32 — product bits [31:0]; holds its value until the next completion.

## Operation
- States:
  - IDLE: reset state.
  - RUN: 32 iterations.
  - DONE: one cycle.
- IDLE or DONE with `start`=1 at an edge: capture the operands.
  - Multiplicand register ← |a|; multiplier register ← |b|. Magnitudes are used only when signed mode is active; otherwise the raw values.
  - Latch sign flag = a[31]^b[31] when signed mode is active, else 0.
  - Clear the 33-bit accumulator; iteration count ← 0; go to RUN.
- IDLE or DONE with `start`=0: go to or stay in IDLE.
- RUN, each edge:
  - If multiplier LSB = 1, accumulator ← accumulator[31:0] + multiplicand, producing a 33-bit sum with carry.
  - Shift {accumulator, multiplier} right by 1; the carry enters bit 32 of the accumulator.
  - Increment the count.
- RUN, edge with count = 31 (the 32nd iteration):
  - Form the 64-bit product from the shifted {accumulator[31:0], multiplier}.
  - If the sign flag is set, two's-complement negate all 64 bits.
  - Write the result to `hi`/`lo`; set `done`=1; go to DONE.
- `start` while in RUN is ignored. Operands already captured are unaffected by later changes on `a`/`b`.
- `start`=1 during DONE is accepted. Back-to-back multiplies issue with no idle cycle.
- Magnitude of -2^31 is 0x80000000, which fits unsigned 32 bits. The maximum product magnitude is 2^62 and never overflows.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0; state IDLE; internal registers 0.
- `reset` takes effect asynchronously at any point, including mid-RUN. The in-flight multiply is discarded and no `done` is produced.
- Deassertion of `reset` is synchronized externally. The first edge after release can accept `start`.
- Start accepted at edge E0 → `busy`=1 after E0.
- Iterations occur at edges E1..E32.
- After E32: `busy`=0, `done`=1, product valid on `hi`/`lo`.
- After E33: `done`=0, unless a restart was accepted at E32+1, in which case `busy`=1.
- Latency from the accepting edge to `done`: 32 cycles. Throughput: one product per 33 cycles.
- `done` is never high while `busy` is high. `busy` and `done` are both registered outputs.

## Configuration
- SEQ_MULT_SIGNED_EN defined:
  - `is_signed`=1 selects signed multiply: magnitude conversion at capture, negation at completion.
  - `is_signed`=0 selects unsigned multiply.
- SEQ_MULT_SIGNED_EN undefined:
  - The abs/negate logic is not compiled in; the sign flag is tied to 0.
  - `is_signed` is ignored; all multiplies are unsigned.
  - Latency is unchanged.

## Test plan
- Unsigned `a`=3, `b`=5, `start` for one cycle → `busy` for 32 cycles, then `done` for 1 cycle with `hi`=0x00000000, `lo`=0x0000000F.
- Unsigned `a`=`b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- `a`=0xFFFFFFFD (-3), `b`=5, `is_signed`=1:
  - With SEQ_MULT_SIGNED_EN → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - Without it → `hi`=0x00000004, `lo`=0xFFFFFFF1.
- Signed `a`=`b`=0x80000000 (with macro) → `hi`=0x40000000, `lo`=0x00000000.
- Start 7x9, then pulse `start` with 2x2 at cycle 5 of RUN → completes with `lo`=63. Start again during the `done` cycle with 2x2 → `lo`=4 exactly 32 cycles later.
- Start 7x9, assert `reset` low at cycle 10 of RUN → immediately `busy`=0, `done`=0, `hi`=`lo`=0, and no `done` follows. After release, 6x7 → `lo`=42.
